// File: rtl/fmab_norm.sv
// fmab_norm -- four-lane accumulator-to-float normaliser.
//
// On a start pulse in IDLE, four signed 32-bit accumulators and their 10-bit
// exponents are captured. Each lane's value is acc * 2^(exp - 284). The lanes
// are then converted to IEEE-754 single precision, in lane order 0..3, through
// a two-stage pipeline:
//   stage 1: sign, magnitude and leading-one position p
//   stage 2: round to nearest-even, pack, output register
// Zero lanes (acc == 0 or exp == 0) give +0. Underflow gives signed zero.
// Overflow gives signed infinity. Denormals are never produced.
//
// Configuration macro FMAB_NORM_BF16_EN:
//   defined   -> round to 7 fraction bits; out_data[31:16] is a bfloat16 and
//                out_data[15:0] is zero
//   undefined -> full fp32 result with 23 fraction bits
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   start               capture pulse, honoured only while busy is low
//   acc0..acc3 [31:0]   signed two's-complement accumulator per lane
//   exp0..exp3 [9:0]    accumulator exponent per lane (0 means the lane is zero)
//   busy                high from the capture until the lane-3 handshake
//   out_valid/out_ready output handshake; a transfer happens when both are high
//   out_data [31:0]     packed float result
//   out_lane [1:0]      lane index of out_data
//   out_last            high together with lane 3
module fmab_norm (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] acc0,
  input  logic [31:0] acc1,
  input  logic [31:0] acc2,
  input  logic [31:0] acc3,
  input  logic [9:0]  exp0,
  input  logic [9:0]  exp1,
  input  logic [9:0]  exp2,
  input  logic [9:0]  exp3,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [1:0]  out_lane,
  output logic        out_last
);

`ifdef FMAB_NORM_BF16_EN
  localparam int FRAC_W = 7;
`else
  localparam int FRAC_W = 23;
`endif

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;          // next lane to issue; bit 2 set = all issued
  logic [3:0][31:0] acc_q, acc_d;
  logic [3:0][9:0]  exp_q, exp_d;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [31:0]      s1_mag_q, s1_mag_d;
  logic [4:0]       s1_p_q, s1_p_d;
  logic [9:0]       s1_exp_q, s1_exp_d;
  logic [1:0]       s1_lane_q, s1_lane_d;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [1:0]       out_lane_q, out_lane_d;
  logic             out_last_q, out_last_d;

  logic             capture, out_adv, s1_adv, issue;
  logic [31:0]      src_acc;
  logic [9:0]       src_exp;
  logic [1:0]       src_lane;

  // Control: capture, lane issue and FSM next state.
  // NOTE: every variable gets a default at the top of an always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    out_adv = !out_valid_q || out_ready;
    s1_adv  = !s1_valid_q || out_adv;
    capture = (state_q == IDLE) && start;
    issue   = s1_adv && (capture || ((state_q == RUN) && !idx_q[2]));

    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    exp_d   = exp_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = RUN;
          idx_d   = 3'd1;   // lane 0 enters stage 1 straight from the ports
          acc_d   = {acc3, acc2, acc1, acc0};
          exp_d   = {exp3, exp2, exp1, exp0};
        end
      end
      RUN: begin
        if (issue) idx_d = idx_q + 3'd1;
        if (out_valid_q && out_ready && out_last_q) state_d = IDLE;
      end
    endcase
  end

  // Stage 1: sign, magnitude, leading-one position. Lane 0 bypasses the
  // capture registers so its result is visible two cycles after start.
  always_comb begin
    if (capture) begin
      src_acc  = acc0;
      src_exp  = exp0;
      src_lane = 2'd0;
    end else begin
      src_acc  = acc_q[idx_q[1:0]];
      src_exp  = exp_q[idx_q[1:0]];
      src_lane = idx_q[1:0];
    end

    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    s1_p_d     = s1_p_q;
    s1_exp_d   = s1_exp_q;
    s1_lane_d  = s1_lane_q;
    if (s1_adv) begin
      s1_valid_d = issue;
      if (issue) begin
        s1_sign_d = src_acc[31];
        // 0x80000000 negates to itself, which read as unsigned is 2^31.
        s1_mag_d  = src_acc[31] ? (32'd0 - src_acc) : src_acc;
        s1_exp_d  = src_exp;
        s1_lane_d = src_lane;
        s1_p_d    = 5'd0;
        for (int i = 0; i < 32; i++) begin
          if (s1_mag_d[i]) s1_p_d = 5'(i);
        end
      end
    end
  end

  // Stage 2: normalise so the leading one sits at bit 31, then round.
  logic [31:0]        s2_norm;
  logic signed [11:0] s2_e_pre, s2_e_fin;
  logic [FRAC_W-1:0]  s2_frac_pre;
  logic               s2_guard, s2_sticky, s2_round_up;
  logic [FRAC_W:0]    s2_mant;
  logic [22:0]        s2_frac;
  logic [31:0]        s2_result;

  always_comb begin
    s2_norm     = s1_mag_q << (5'd31 - s1_p_q);
    s2_e_pre    = $signed({7'd0, s1_p_q}) + $signed({2'd0, s1_exp_q}) - 12'sd157;
    s2_frac_pre = s2_norm[30 -: FRAC_W];
    s2_guard    = s2_norm[30 - FRAC_W];
    s2_sticky   = |s2_norm[29 - FRAC_W:0];
    // Small magnitudes shift in zeros below the fraction, so guard and sticky
    // are clear and the result is exact without a separate path.
    s2_round_up = s2_guard && (s2_sticky || s2_frac_pre[0]);
    s2_mant     = {1'b0, s2_frac_pre} + {{FRAC_W{1'b0}}, s2_round_up};
    // A carry out leaves the fraction all-zero and bumps the exponent.
    s2_e_fin    = s2_e_pre + $signed({11'd0, s2_mant[FRAC_W]});
    s2_frac     = '0;
    s2_frac[22 -: FRAC_W] = s2_mant[FRAC_W-1:0];

    // A clear bit 31 after normalising means the magnitude was zero.
    if (!s2_norm[31] || (s1_exp_q == 10'd0)) s2_result = '0;
    else if (s2_e_fin >= 12'sd255)            s2_result = {s1_sign_q, 8'hFF, 23'd0};
    else if (s2_e_fin <= 12'sd0)              s2_result = {s1_sign_q, 31'd0};
    else                                      s2_result = {s1_sign_q, s2_e_fin[7:0], s2_frac};
  end

  // Output register: holds its contents while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_last_d  = out_last_q;
    if (out_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_data_d = s2_result;
        out_lane_d = s1_lane_q;
        out_last_d = (s1_lane_q == 2'd3);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_last_q  <= out_last_d;
    end
  end

  // NOTE: capture and stage-1 data registers are not reset; their contents are
  // only consumed under a valid bit that reset does clear.
  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    exp_q     <= exp_d;
    s1_sign_q <= s1_sign_d;
    s1_mag_q  <= s1_mag_d;
    s1_p_q    <= s1_p_d;
    s1_exp_q  <= s1_exp_d;
    s1_lane_q <= s1_lane_d;
  end

  assign busy      = (state_q == RUN);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fmab_norm.sv
// tb_fmab_norm -- self-checking bench for fmab_norm.
// Each test task drives a scenario and compares the collected outputs against
// a reference model that converts acc * 2^(exp - 284) with plain integer
// arithmetic. Honours FMAB_NORM_BF16_EN the same way the design does.
`timescale 1ns/1ps
module tb_fmab_norm;

`ifdef FMAB_NORM_BF16_EN
  localparam int F = 7;
`else
  localparam int F = 23;
`endif

  logic        clk = 1'b0;
  logic        reset, start, out_ready;
  logic [31:0] acc0, acc1, acc2, acc3;
  logic [9:0]  exp0, exp1, exp2, exp3;
  logic        busy, out_valid, out_last;
  logic [31:0] out_data;
  logic [1:0]  out_lane;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] a_in [4];
  logic [9:0]  e_in [4];
  logic [31:0] want [4];
  logic [31:0] got_data [4];
  int          got_lane [4];
  logic        got_last [4];
  int          got_cyc  [4];
  int          n_got, first_valid_cyc, busy_low_cyc, stable_bad, extra_xfers;
  logic        busy_at_last;

  always #5 clk = ~clk;

  fmab_norm dut (
    .clk(clk), .reset(reset), .start(start),
    .acc0(acc0), .acc1(acc1), .acc2(acc2), .acc3(acc3),
    .exp0(exp0), .exp1(exp1), .exp2(exp2), .exp3(exp3),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_lane(out_lane), .out_last(out_last)
  );

  // Reference: value = acc * 2^(exp-284), rounded to F fraction bits.
  function automatic logic [31:0] ref_lane(input logic [31:0] acc, input logic [9:0] ex);
    longint mag, q, rem, half, frac;
    int     p, e, sh;
    logic   s;
    if (acc == 32'd0 || ex == 10'd0) return 32'd0;
    s   = acc[31];
    mag = {32'd0, acc};
    if (s) mag = 64'sd4294967296 - mag;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    e = p + int'(ex) - 157;
    if (p <= F) begin
      q = mag << (F - p);
    end else begin
      sh   = p - F;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
    end
    if (q == (longint'(1) << (F + 1))) begin
      q = q >> 1;
      e++;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    frac = q - (longint'(1) << F);
    return {s, 8'(e), 23'(frac << (23 - F))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_inputs();
    acc0 = a_in[0]; acc1 = a_in[1]; acc2 = a_in[2]; acc3 = a_in[3];
    exp0 = e_in[0]; exp1 = e_in[1]; exp2 = e_in[2]; exp3 = e_in[3];
  endtask

  task automatic scribble();
    acc0 = $urandom; acc1 = $urandom; acc2 = $urandom; acc3 = $urandom;
    exp0 = 10'($urandom); exp1 = 10'($urandom); exp2 = 10'($urandom); exp3 = 10'($urandom);
  endtask

  task automatic compute_want();
    for (int i = 0; i < 4; i++) want[i] = ref_lane(a_in[i], e_in[i]);
  endtask

  function automatic logic [31:0] rand_acc();
    logic [31:0] a;
    a = $urandom >> $urandom_range(0, 31);
    if ($urandom_range(0, 1) == 1) a = 32'd0 - a;
    case ($urandom_range(0, 11))
      0: a = 32'd0;
      1: a = 32'h8000_0000;
      default: ;
    endcase
    return a;
  endfunction

  // Pulses start with a_in/e_in and records every transfer.
  // mode 0: ready held high; 1: random ready; 2: ready low for the first
  // 5 cycles of lane 0; 3: like 0 but start re-pulsed with junk while busy.
  task automatic run_op(input int mode);
    logic [31:0] pd;
    logic [1:0]  pl;
    logic        plast, pstall;
    n_got = 0; first_valid_cyc = -1; busy_low_cyc = -1;
    stable_bad = 0; extra_xfers = 0; busy_at_last = 1'b0;
    pstall = 1'b0; pd = '0; pl = '0; plast = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got_data[i] = 'x; got_lane[i] = -1; got_last[i] = 1'bx; got_cyc[i] = -1;
    end
    drive_inputs();
    start     = 1'b1;
    out_ready = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      step();
      start = (mode == 3 && c <= 3) ? 1'b1 : 1'b0;
      scribble();
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (pstall && (!out_valid || out_data !== pd || out_lane !== pl || out_last !== plast))
        stable_bad++;
      case (mode)
        1:       out_ready = ($urandom_range(0, 2) != 0);
        2:       out_ready = !(first_valid_cyc >= 0 && c < first_valid_cyc + 5);
        default: out_ready = 1'b1;
      endcase
      if (out_valid && out_ready) begin
        if (n_got < 4) begin
          got_data[n_got] = out_data;
          got_lane[n_got] = int'(out_lane);
          got_last[n_got] = out_last;
          got_cyc[n_got]  = c;
        end else begin
          extra_xfers++;
        end
        if (out_last) busy_at_last = busy;
        n_got++;
      end
      pstall = out_valid && !out_ready;
      pd = out_data; pl = out_lane; plast = out_last;
      if (n_got >= 4 && !busy) begin
        busy_low_cyc = c;
        break;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      step();
      if (out_valid) extra_xfers++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin a_in[i] = 32'h0000_4000; e_in[i] = 10'd270; end
    drive_inputs();
    step();
    step();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++;
    if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 00000000", out_data); end
    n_checks++;
    if (out_lane !== 2'd0) begin n_fail++; $display("FAIL reset_out_lane: got %0d want 0", out_lane); end
    n_checks++;
    if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_out_last: got %b want 0", out_last); end
    reset = 1'b0; start = 1'b0;
    repeat (3) step();
    n_checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_with_reset: got busy=%b out_valid=%b want 0/0", busy, out_valid);
    end
  endtask

  task automatic test_unity_sign();
    a_in[0] = 32'h0000_4000; e_in[0] = 10'd270;
    a_in[1] = 32'hFFFF_C000; e_in[1] = 10'd270;
    a_in[2] = 32'h0000_4000; e_in[2] = 10'd271;
    a_in[3] = 32'h0000_0003; e_in[3] = 10'd280;
    compute_want();
    want[0] = 32'h3F80_0000;
    want[1] = 32'hBF80_0000;
    run_op(0);
    n_checks++;
    if (first_valid_cyc !== 2) begin n_fail++; $display("FAIL unity_latency: got %0d want 2", first_valid_cyc); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_lane[i] != i || got_last[i] !== (i == 3) || got_cyc[i] != 2 + i) begin
        n_fail++;
        $display("FAIL unity_lane%0d: got data=%h lane=%0d last=%b cyc=%0d want data=%h lane=%0d last=%b cyc=%0d",
                 i, got_data[i], got_lane[i], got_last[i], got_cyc[i], want[i], i, (i == 3), 2 + i);
      end
    end
    n_checks++;
    if (busy_low_cyc != 6 || busy_at_last !== 1'b1 || extra_xfers != 0) begin
      n_fail++;
      $display("FAIL unity_busy: got busy_low_cyc=%0d busy_at_last=%b extra=%0d want 6/1/0",
               busy_low_cyc, busy_at_last, extra_xfers);
    end
  endtask

  task automatic test_rounding();
    a_in[0] = 32'h0100_0003; e_in[0] = 10'd260;
    a_in[1] = 32'h0100_0001; e_in[1] = 10'd260;
    a_in[2] = 32'h01FF_FFFF; e_in[2] = 10'd260;
    a_in[3] = 32'hFE00_0001; e_in[3] = 10'd300;
    compute_want();
`ifdef FMAB_NORM_BF16_EN
    want[0] = 32'h3F80_0000;
`else
    want[0] = 32'h3F80_0002;
`endif
    run_op(0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_lane[i] != i || got_last[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL round_lane%0d: got data=%h lane=%0d last=%b want data=%h lane=%0d last=%b",
                 i, got_data[i], got_lane[i], got_last[i], want[i], i, (i == 3));
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] k_acc [8];
    logic [9:0]  k_exp [8];
    logic [31:0] k_res [8];
    k_acc = '{32'd0, 32'd5, 32'h4000_0000, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    k_exp = '{10'd300, 10'd0, 10'd400, 10'd100, 10'd411, 10'd412, 10'd158, 10'd157};
    k_res = '{32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 32'h0000_0000,
              32'h7F00_0000, 32'h7F80_0000, 32'h0080_0000, 32'h0000_0000};
    for (int op = 0; op < 2; op++) begin
      for (int i = 0; i < 4; i++) begin
        a_in[i] = k_acc[op * 4 + i]; e_in[i] = k_exp[op * 4 + i]; want[i] = k_res[op * 4 + i];
      end
      run_op(0);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_data[i] !== want[i] || got_lane[i] != i) begin
          n_fail++;
          $display("FAIL special%0d_lane%0d: got data=%h lane=%0d want data=%h lane=%0d",
                   op, i, got_data[i], got_lane[i], want[i], i);
        end
      end
    end
    // Negative overflow, negative underflow, overflow by rounding carry, -2^31.
    a_in[0] = 32'hC000_0000; e_in[0] = 10'd400; want[0] = 32'hFF80_0000;
    a_in[1] = 32'hFFFF_FFFF; e_in[1] = 10'd100; want[1] = 32'h8000_0000;
    a_in[2] = 32'h01FF_FFFF; e_in[2] = 10'd387; want[2] = 32'h7F80_0000;
    a_in[3] = 32'h8000_0000; e_in[3] = 10'd200; want[3] = 32'hA500_0000;
    run_op(0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_lane[i] != i) begin
        n_fail++;
        $display("FAIL signed_special_lane%0d: got data=%h lane=%0d want data=%h lane=%0d",
                 i, got_data[i], got_lane[i], want[i], i);
      end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin a_in[i] = rand_acc(); e_in[i] = 10'($urandom_range(120, 300)); end
    compute_want();
    run_op(2);
    n_checks++;
    if (stable_bad != 0 || first_valid_cyc != 2) begin
      n_fail++;
      $display("FAIL bp_hold: got unstable=%0d first_valid=%0d want 0/2", stable_bad, first_valid_cyc);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_lane[i] != i || got_last[i] !== (i == 3) || got_cyc[i] != 7 + i) begin
        n_fail++;
        $display("FAIL bp_lane%0d: got data=%h lane=%0d last=%b cyc=%0d want data=%h lane=%0d last=%b cyc=%0d",
                 i, got_data[i], got_lane[i], got_last[i], got_cyc[i], want[i], i, (i == 3), 7 + i);
      end
    end
    n_checks++;
    if (busy_low_cyc != 11 || busy_at_last !== 1'b1 || extra_xfers != 0) begin
      n_fail++;
      $display("FAIL bp_busy: got busy_low_cyc=%0d busy_at_last=%b extra=%0d want 11/1/0",
               busy_low_cyc, busy_at_last, extra_xfers);
    end
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < 4; i++) begin a_in[i] = rand_acc(); e_in[i] = 10'($urandom_range(120, 300)); end
    compute_want();
    run_op(3);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_lane[i] != i) begin
        n_fail++;
        $display("FAIL busy_start_lane%0d: got data=%h lane=%0d want data=%h lane=%0d",
                 i, got_data[i], got_lane[i], want[i], i);
      end
    end
    n_checks++;
    if (n_got != 4 || extra_xfers != 0) begin
      n_fail++;
      $display("FAIL busy_start_count: got %0d transfers, %0d extra want 4/0", n_got, extra_xfers);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin a_in[i] = rand_acc(); e_in[i] = 10'($urandom_range(120, 300)); end
    drive_inputs();
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_lane !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_pre_lane1: got valid=%b lane=%0d want 1/1", out_valid, out_lane);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got valid=%b busy=%b want 0/0", out_valid, busy);
    end
    reset = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin a_in[i] = rand_acc(); e_in[i] = 10'($urandom_range(120, 300)); end
    compute_want();
    run_op(0);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (got_data[i] !== want[i] || got_lane[i] != i || got_cyc[i] != 2 + i) begin
        n_fail++;
        $display("FAIL mid_after_lane%0d: got data=%h lane=%0d cyc=%0d want data=%h lane=%0d cyc=%0d",
                 i, got_data[i], got_lane[i], got_cyc[i], want[i], i, 2 + i);
      end
    end
  endtask

  task automatic test_random();
    for (int op = 0; op < 30; op++) begin
      for (int i = 0; i < 4; i++) begin
        a_in[i] = rand_acc();
        e_in[i] = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(100, 450));
      end
      compute_want();
      run_op(($urandom_range(0, 1) == 1) ? 1 : 0);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (got_data[i] !== want[i] || got_lane[i] != i || got_last[i] !== (i == 3)) begin
          n_fail++;
          $display("FAIL rand%0d_lane%0d: acc=%h exp=%0d got data=%h lane=%0d last=%b want data=%h",
                   op, i, a_in[i], e_in[i], got_data[i], got_lane[i], got_last[i], want[i]);
        end
      end
      n_checks++;
      if (stable_bad != 0 || extra_xfers != 0 || busy_low_cyc < 0) begin
        n_fail++;
        $display("FAIL rand%0d_flow: got unstable=%0d extra=%0d busy_low=%0d want 0/0/>=0",
                 op, stable_bad, extra_xfers, busy_low_cyc);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b1;
    acc0 = '0; acc1 = '0; acc2 = '0; acc3 = '0;
    exp0 = '0; exp1 = '0; exp2 = '0; exp3 = '0;
    #1;
    test_reset();
    test_unity_sign();
    test_rounding();
    test_special();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
